// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_pkg
// Purpose  : Shared FSM state type, default geometry and field widths for the
//            instruction-cache fetch block.
// Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

   typedef enum logic [1:0] {
      LOOKUP  = 2'd0,
      REFILL  = 2'd1,
      RESPOND = 2'd2
   } fetchState_t;

   localparam int c_DEF_NUM_LINES      = 16;
   localparam int c_DEF_WORDS_PER_LINE = 4;
   localparam int c_OB                 = $clog2(c_DEF_WORDS_PER_LINE);
   localparam int c_IB                 = $clog2(c_DEF_NUM_LINES);
   localparam int c_TAG_W              = 32 - 2 - c_OB - c_IB;

   // Tag width for an arbitrary geometry: everything above offset and index.
   function automatic int tagWidth(input int numLines, input int wordsPerLine);
      return 32 - 2 - $clog2(numLines) - $clog2(wordsPerLine);
   endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_ram.sv
`default_nettype none
// ============================================================================
// Module   : icache_line_ram
// Purpose  : Direct-mapped data, tag and valid storage; one combinational read
//            port, one synchronous word write port.
// Revision : 1.0 - initial release
// ============================================================================
module icache_line_ram
   import icache_pkg::*;
#(
   parameter int NUM_LINES      = c_DEF_NUM_LINES,
   parameter int WORDS_PER_LINE = c_DEF_WORDS_PER_LINE,
   parameter int IB             = $clog2(NUM_LINES),
   parameter int OB             = $clog2(WORDS_PER_LINE),
   parameter int TAG_W          = tagWidth(NUM_LINES, WORDS_PER_LINE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IB-1:0]    rdIndex,
   input  logic [OB-1:0]    rdOffset,
   output logic [31:0]      rdData,
   output logic [TAG_W-1:0] rdTag,
   output logic             rdValid,
   input  logic             wrEn,
   input  logic [IB-1:0]    wrIndex,
   input  logic [OB-1:0]    wrOffset,
   input  logic [31:0]      wrData,
   input  logic             tagWrEn,
   input  logic [TAG_W-1:0] wrTag,
   input  logic             invEn,
   input  logic [IB-1:0]    invIndex
);

   logic [31:0]          r_data  [NUM_LINES][WORDS_PER_LINE];
   logic [TAG_W-1:0]     r_tag   [NUM_LINES];
   logic [NUM_LINES-1:0] r_valid;

   always_ff @(posedge clk) begin
      if (wrEn) begin
         r_data[wrIndex][wrOffset] <= wrData;
      end
   end

   always_ff @(posedge clk) begin
      if (tagWrEn) begin
         r_tag[wrIndex] <= wrTag;
      end
   end

   // A line is invalidated when its refill starts and only marked valid once
   // its last word lands, so an aborted refill never exposes mixed data.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
      end else begin
         if (invEn) begin
            r_valid[invIndex] <= 1'b0;
         end
         if (tagWrEn) begin
            r_valid[wrIndex] <= 1'b1;
         end
      end
   end

   assign rdData  = r_data[rdIndex][rdOffset];
   assign rdTag   = r_tag[rdIndex];
   assign rdValid = r_valid[rdIndex];

endmodule
`default_nettype wire

// File: rtl/icache_fetch.sv
`default_nettype none
// ============================================================================
// Module   : icache_fetch
// Purpose  : Read-only direct-mapped instruction cache with word-by-word refill.
//            Optional hit/miss counters enabled by defining ICACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module icache_fetch
   import icache_pkg::*;
#(
   parameter int NUM_LINES      = c_DEF_NUM_LINES,
   parameter int WORDS_PER_LINE = c_DEF_WORDS_PER_LINE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PCF,
   output logic [31:0] InstrF,
   output logic        icache_stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int c_OFF_BITS = $clog2(WORDS_PER_LINE);
   localparam int c_IDX_BITS = $clog2(NUM_LINES);
   localparam int c_TAG_BITS = tagWidth(NUM_LINES, WORDS_PER_LINE);

   fetchState_t           r_state;
   logic [c_OFF_BITS-1:0] r_count;
   logic [c_IDX_BITS-1:0] r_index;
   logic [c_TAG_BITS-1:0] r_tag;
   logic                  r_memReq;

   logic [c_OFF_BITS-1:0] w_offset;
   logic [c_IDX_BITS-1:0] w_index;
   logic [c_TAG_BITS-1:0] w_tag;
   logic [31:0]           w_rdData;
   logic [c_TAG_BITS-1:0] w_rdTag;
   logic                  w_rdValid;
   logic                  w_hit;
   logic                  w_miss;
   logic                  w_accept;
   logic                  w_lastWord;
   logic                  w_unusedPcfLsb;

   assign w_offset       = PCF[c_OFF_BITS+1:2];
   assign w_index        = PCF[c_OFF_BITS+c_IDX_BITS+1:c_OFF_BITS+2];
   assign w_tag          = PCF[31:c_OFF_BITS+c_IDX_BITS+2];
   assign w_unusedPcfLsb = ^PCF[1:0];

   icache_line_ram #(
      .NUM_LINES      (NUM_LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .IB             (c_IDX_BITS),
      .OB             (c_OFF_BITS),
      .TAG_W          (c_TAG_BITS)
   ) u_lineRam (
      .clk      (clk),
      .reset    (reset),
      .rdIndex  (w_index),
      .rdOffset (w_offset),
      .rdData   (w_rdData),
      .rdTag    (w_rdTag),
      .rdValid  (w_rdValid),
      .wrEn     (w_accept),
      .wrIndex  (r_index),
      .wrOffset (r_count),
      .wrData   (mem_rdata),
      .tagWrEn  (w_accept && w_lastWord),
      .wrTag    (r_tag),
      .invEn    (w_miss),
      .invIndex (w_index)
   );

   // Hit is only meaningful in LOOKUP; every other state stalls the core.
   assign w_hit      = (r_state == LOOKUP) && w_rdValid && (w_rdTag == w_tag);
   assign w_miss     = (r_state == LOOKUP) && !w_hit;
   assign w_accept   = (r_state == REFILL) && mem_ready;
   assign w_lastWord = &r_count;

   assign icache_stall = !w_hit;
   assign InstrF       = w_hit ? w_rdData : 32'h0;
   assign mem_req      = r_memReq;
   assign mem_addr     = {r_tag, r_index, r_count, 2'b00};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= LOOKUP;
         r_count  <= '0;
         r_index  <= '0;
         r_tag    <= '0;
         r_memReq <= 1'b0;
      end else begin
         case (r_state)
            LOOKUP: begin
               if (w_miss) begin
                  r_index  <= w_index;
                  r_tag    <= w_tag;
                  r_count  <= '0;
                  r_memReq <= 1'b1;
                  r_state  <= REFILL;
               end
            end
            REFILL: begin
               if (mem_ready) begin
                  if (w_lastWord) begin
                     r_count  <= '0;
                     r_memReq <= 1'b0;
                     r_state  <= RESPOND;
                  end else begin
                     r_count <= r_count + 1'b1;
                  end
               end
            end
            RESPOND: begin
               r_state <= LOOKUP;
            end
            default: begin
               r_state  <= LOOKUP;
               r_memReq <= 1'b0;
            end
         endcase
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] r_hitCount;
   logic [31:0] r_missCount;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hitCount  <= '0;
         r_missCount <= '0;
      end else begin
         if (w_hit) begin
            r_hitCount <= r_hitCount + 32'd1;
         end
         if (w_miss) begin
            r_missCount <= r_missCount + 32'd1;
         end
      end
   end

   assign hit_count  = r_hitCount;
   assign miss_count = r_missCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_fetch
// Purpose  : Scoreboard bench for icache_fetch against a line-level cache model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_fetch;

   localparam int LINES = 16;
   localparam int WPL   = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
      int          nMiss;
      int          expStall;
   } fetchExp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PCF;
   logic [31:0] InstrF;
   logic        icache_stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ready;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int checks = 0;
   int errors = 0;
   int mode   = 0;

   fetchExp_t   fetchQ[$];
   logic [31:0] addrQ[$];
   bit          mValid[LINES];
   logic [31:0] mTag[LINES];

   icache_fetch dut (
      .clk          (clk),
      .reset        (reset),
      .PCF          (PCF),
      .InstrF       (InstrF),
      .icache_stall (icache_stall),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count    (hit_count),
      .miss_count   (miss_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h20080005;
         32'h4:   return 32'h2009000C;
         32'h8:   return 32'h01095020;
         32'hC:   return 32'hAC0A0054;
         default: return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
      endcase
   endfunction

   assign mem_rdata = memWord(mem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clearModel();
      foreach (mValid[i]) mValid[i] = 1'b0;
   endtask

   // Model a fetch: predict hit/miss, queue the refill addresses of a miss,
   // and optionally queue the expected instruction word for the monitor.
   task automatic prepFetch(input logic [31:0] pc, input int priorMiss,
                            input int expStall, input bit pushFetch);
      int          idx;
      logic [31:0] tag;
      bit          hit;
      fetchExp_t   e;
      idx = int'((pc / (4 * WPL)) % LINES);
      tag = pc / (4 * WPL * LINES);
      hit = mValid[idx] && (mTag[idx] == tag);
      if (!hit) begin
         for (int k = 0; k < WPL; k++) addrQ.push_back((pc & ~32'(4 * WPL - 1)) + 32'(4 * k));
         mValid[idx] = 1'b1;
         mTag[idx]   = tag;
      end
      if (pushFetch) begin
         e.pc       = pc;
         e.word     = memWord(pc & ~32'h3);
         e.nMiss    = priorMiss + (hit ? 0 : 1);
         e.expStall = expStall;
         fetchQ.push_back(e);
      end
   endtask

   task automatic waitDone(input bit first);
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (first && i == 0) begin
            chk("first lookup stall", icache_stall, 1);
            chk("first lookup InstrF", InstrF, 0);
            chk("first lookup mem_req", mem_req, 0);
         end
         if (!icache_stall) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL fetch timeout: stall %b after 200 cycles, expected 0", icache_stall);
      end
   endtask

   task automatic waitAccepts(input int n);
      int acc = 0;
      for (int i = 0; i < 50 && acc < n; i++) begin
         @(negedge clk);
         if (mem_req && mem_ready) acc++;
      end
      if (acc < n) begin
         checks++;
         errors++;
         $display("FAIL accept timeout: %0d refill words seen, expected %0d", acc, n);
      end
   endtask

   task automatic doFetch(input logic [31:0] pc);
      @(posedge clk);
      #1;
      prepFetch(pc, 0, -1, 1);
      PCF = pc;
      waitDone(1'b0);
   endtask

   task automatic resetPulse();
      @(posedge clk);
      #1;
      reset = 1'b1;
      fetchQ.delete();
      addrQ.delete();
      clearModel();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Memory handshake driver: always ready, alternating, or random.
   initial begin
      mem_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = !mem_ready;
            default: mem_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: checks refill addresses as words are accepted and pops the
   // expected instruction whenever the cache stops stalling.
   initial begin : monitor
      int        stallCnt;
      int        reqCnt;
      fetchExp_t e;
      stallCnt = 0;
      reqCnt   = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stallCnt = 0;
            reqCnt   = 0;
         end else begin
            if (mem_req) reqCnt++;
            if (mem_req && mem_ready) begin
               if (addrQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected refill: mem_addr %h, none expected", mem_addr);
               end else begin
                  chk("mem_addr", mem_addr, addrQ.pop_front());
               end
            end
            if (icache_stall) begin
               stallCnt++;
               chk("InstrF while stalled", InstrF, 0);
            end else begin
               if (fetchQ.size() > 0) begin
                  e = fetchQ.pop_front();
                  chk($sformatf("InstrF pc=%h", e.pc), InstrF, e.word);
                  chk("mem_req on hit", mem_req, 0);
                  chk($sformatf("stall cycles pc=%h", e.pc), 32'(stallCnt),
                      32'((e.nMiss == 0) ? 0 : reqCnt + 2 * e.nMiss));
                  if (e.expStall >= 0)
                     chk($sformatf("fixed stall pc=%h", e.pc), 32'(stallCnt), 32'(e.expStall));
               end
               stallCnt = 0;
               reqCnt   = 0;
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      PCF   = 32'h0;
      clearModel();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      prepFetch(32'h0, 0, 6, 1);
      waitDone(1'b1);
      doFetch(32'h4);
      doFetch(32'h8);
`ifdef ICACHE_STATS_EN
      @(posedge clk);
      #1;
      chk("hit_count", hit_count, 32'd3);
      chk("miss_count", miss_count, 32'd1);
`endif

      mode = 1;
      doFetch(32'h100);
      doFetch(32'h0);
      mode = 0;

      // Reset in the middle of a refill: the restarted fetch must miss again.
      @(posedge clk);
      #1;
      prepFetch(32'h40, 0, -1, 0);
      PCF = 32'h40;
      waitAccepts(2);
      @(posedge clk);
      #1;
      reset = 1'b1;
      fetchQ.delete();
      addrQ.delete();
      clearModel();
      @(posedge clk);
      #1;
      reset = 1'b0;
      prepFetch(32'h40, 0, 6, 1);
      waitDone(1'b1);

      // PCF moves during a refill: the original line still completes.
      resetPulse();
      prepFetch(32'h40, 0, -1, 0);
      PCF = 32'h40;
      waitAccepts(1);
      @(posedge clk);
      #1;
      prepFetch(32'h80, 1, 12, 1);
      PCF = 32'h80;
      waitDone(1'b0);
      doFetch(32'h40);
      doFetch(32'h8C);

      mode = 2;
      for (int n = 0; n < 150; n++) begin
         doFetch((32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2)
                 | 32'($urandom_range(0, 3)));
      end

      @(posedge clk);
      #1;
      if (fetchQ.size() != 0 || addrQ.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL leftover expectations: %0d fetches %0d refills, expected 0 0",
                  fetchQ.size(), addrQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/icache_fetch.md
ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16, number of direct-mapped lines (power of two, 2..256).
REQ-002 SHALL have parameter WORDS_PER_LINE, default 4, 32-bit words per line (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port PCF  input  32  fetch address from core; bits [1:0] ignored.
REQ-006 SHALL have port InstrF  output  32  instruction word for PCF.
REQ-007 SHALL have port icache_stall  output  1  high while InstrF is not valid for PCF; core ORs it into StallF/StallD.
REQ-008 SHALL have port mem_req  output  1  refill word request to main memory.
REQ-009 SHALL have port mem_addr  output  32  word-aligned refill address.
REQ-010 SHALL have port mem_rdata  input  32  refill data, valid when mem_ready high.
REQ-011 SHALL have port mem_ready  input  1  memory accepts mem_req and returns mem_rdata in the same cycle.

Function
REQ-012 SHALL split PCF as offset = PCF[2+OB-1:2], index = next IB bits, tag = remaining upper bits (OB=log2 WORDS_PER_LINE, IB=log2 NUM_LINES).
REQ-013 SHALL implement FSM states LOOKUP, REFILL, RESPOND.
REQ-014 In LOOKUP, hit (valid[index] and tag match) SHALL drive InstrF from the data array combinationally, icache_stall=0, zero-cycle latency.
REQ-015 In LOOKUP, miss SHALL assert icache_stall combinationally, latch index and tag, clear word counter, and go to REFILL next cycle.
REQ-016 In REFILL, mem_req SHALL be 1 and mem_addr = {latched tag, latched index, counter, 2'b00}; icache_stall=1.
REQ-017 Each cycle with mem_ready=1 in REFILL SHALL write mem_rdata to data[index][counter] and increment counter; mem_ready=0 SHALL hold counter and mem_addr.
REQ-018 On acceptance of word WORDS_PER_LINE-1 SHALL set valid[index], write tag, and go to RESPOND; counter wraps to 0.
REQ-019 RESPOND SHALL last one cycle with icache_stall=1, mem_req=0, then return to LOOKUP where the access hits.
REQ-020 PCF change during REFILL/RESPOND SHALL NOT alter the latched refill; the new PCF is looked up on return to LOOKUP.
REQ-021 mem_req SHALL be 0 in LOOKUP and RESPOND.
REQ-022 A refill replacing a valid line with a different tag SHALL overwrite it (no write-back; read-only cache).

Reset
REQ-023 reset SHALL clear all valid bits, counter to 0, FSM to LOOKUP, mem_req to 0, taking priority over all other events.
REQ-024 reset during REFILL SHALL abort the refill; the partially filled line SHALL remain invalid.
REQ-025 After reset, icache_stall SHALL be 1 in the first LOOKUP cycle for any PCF (all miss); InstrF SHALL be 32'h0 while icache_stall=1.

Configuration
REQ-026 With ICACHE_STATS_EN defined, SHALL add outputs hit_count[31:0] and miss_count[31:0], incremented once per LOOKUP hit cycle (with no stall) and once per LOOKUP-to-REFILL transition, cleared by reset, wrapping at 2^32.
REQ-027 Without ICACHE_STATS_EN, those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package icache_pkg SHALL hold the FSM state type and localparams for OB, IB, tag width.
REQ-029 Data and tag/valid storage SHALL be one sub-module icache_line_ram (1 read port, 1 write port, synchronous write); FSM and compare in icache_fetch.

Verification
REQ-030 Reset, PCF=0x0, memory returns 0x20080005,0x2009000C,0x01095020,0xAC0A0054 with mem_ready=1 -> mem_addr 0x0,0x4,0x8,0xC; stall high 6 cycles; then InstrF=0x20080005, stall 0.
REQ-031 After REQ-030, PCF=0x8 -> same-cycle InstrF=0x01095020, icache_stall=0, mem_req=0.
REQ-032 PCF=0x100 (same index, different tag at NUM_LINES=16) with mem_ready toggling 1,0,1,0... -> counter holds on 0 cycles, line replaced; PCF=0x0 afterwards misses again.
REQ-033 reset pulsed after 2 refill words of PCF=0x40 -> mem_req=0 next cycle; PCF=0x40 then misses, refill restarts at mem_addr 0x40.
REQ-034 PCF changed 0x40->0x80 mid-refill -> refill of 0x40 line completes, then 0x80 lookup misses and refills 0x80.
REQ-035 With ICACHE_STATS_EN, REQ-030 then 3 hit cycles -> miss_count=1, hit_count=3.
